display_scan_mux: RTL and testbench

//  Time-multiplexed scanner for a multi-digit 7-segment display. Holds a packed
//  hex value and sequences one nibble plus decimal point per digit slot into the

---
 rtl/display_scan_mux_pkg.sv | 20 ++
 rtl/display_scan_mux_scan_tick_gen.sv | 38 +++
 rtl/display_scan_mux.sv | 145 ++++++++++++++
 tb/tb_display_scan_mux.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_mux_pkg.sv
// rtl/display_scan_mux_pkg.sv - shared constants and anode polarity helper for the display scanner
//
// Contents:
//   DEFAULT_NUM_DIGITS / DEFAULT_DIV / DEFAULT_GUARD  default scan geometry
//   BLANK_NIBBLE                                      nibble value treated as a leading zero
//   anode_level()                                     maps "digit lit" to the pin level

package display_scan_mux_pkg;

  localparam int         DEFAULT_NUM_DIGITS = 4;
  localparam int         DEFAULT_DIV        = 50000;
  localparam int         DEFAULT_GUARD      = 2;
  localparam logic [3:0] BLANK_NIBBLE       = 4'h0;

  // Pin level for one anode: active-low boards invert the "lit" request.
  function automatic logic anode_level(input logic active, input logic anode_low);
    return anode_low ? ~active : active;
  endfunction

endpackage

// File: rtl/display_scan_mux_scan_tick_gen.sv
// rtl/display_scan_mux_scan_tick_gen.sv - per-digit slot prescaler with dead-time flag
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous reset, active-high
//   enable  in   1 = count, 0 = hold count
//   tick    out  high during the last cycle of a slot (count = DIV-1) while enabled
//   guard   out  high while count < GUARD (anodes must stay dark)

module scan_tick_gen #(
  parameter int DIV   = 50000,
  parameter int GUARD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick,
  output logic guard
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) count <= '0;
      else               count <= count + CW'(1);
    end
  end

  assign tick  = enable && (count == LAST);
  assign guard = int'(count) < GUARD;

endmodule

// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - time-multiplexed 7-segment digit scanner with dead-time and leading-zero blanking
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active-high
//   load      in   strobe: capture valor/dp_mask into the pending buffer
//   valor     in   packed hex value, digit 0 = bits [3:0] (rightmost)
//   dp_mask   in   decimal point per digit, 1 = lit
//   blank_lz  in   1 = blank leading zero digits
//   enable    in   0 = display dark, scan frozen
//   dado      out  nibble of the selected digit, to the decoder
//   dp        out  decimal point of the selected digit, to the decoder
//   anodos    out  one-hot digit enables, polarity set by ANODE_LOW
//   frame     out  one-cycle pulse after the digit index wraps to 0

module display_scan_mux
  import display_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
  parameter int DIV        = DEFAULT_DIV,
  parameter int GUARD      = DEFAULT_GUARD,
  parameter int ANODE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] valor,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [3:0]              dado,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anodos,
  output logic                    frame
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic POL_LOW = (ANODE_LOW != 0);

  logic                    tick;
  logic                    guard;
  logic                    wrap;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shown;
  logic [4*NUM_DIGITS-1:0] pending;
  logic [NUM_DIGITS-1:0]   shown_dp;
  logic [NUM_DIGITS-1:0]   pending_dp;
  logic                    pend_valid;

  logic [NUM_DIGITS-1:0]   lz_dark;
  logic                    zero_above;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_dark;
  logic                    show_anode;
  logic [NUM_DIGITS-1:0]   anode_next;
  logic [NUM_DIGITS-1:0]   anode_off;

  scan_tick_gen #(
    .DIV   (DIV),
    .GUARD (GUARD)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick),
    .guard  (guard)
  );

  assign wrap = tick && (idx == LAST_IDX);

  // Leading-zero mask: walk down from the top digit while everything above
  // (inclusive) is a zero nibble without a decimal point. Digit 0 never blanks.
  always_comb begin
    lz_dark    = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (shown[4*i +: 4] == BLANK_NIBBLE) && !shown_dp[i];
      lz_dark[i] = blank_lz && zero_above;
    end
  end

  always_comb begin
    cur_nib  = BLANK_NIBBLE;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib  = shown[4*i +: 4];
        cur_dp   = shown_dp[i];
        cur_dark = lz_dark[i];
      end
    end
  end

  assign show_anode = enable && !guard && !cur_dark;

  always_comb begin
    anode_next = '0;
    anode_off  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      anode_next[i] = anode_level(show_anode && (idx == IW'(i)), POL_LOW);
      anode_off[i]  = anode_level(1'b0, POL_LOW);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      shown      <= '0;
      shown_dp   <= '0;
      pending    <= '0;
      pending_dp <= '0;
      pend_valid <= 1'b0;
      dado       <= '0;
      dp         <= 1'b0;
      anodos     <= anode_off;
      frame      <= 1'b0;
    end else begin
      if (tick) idx <= wrap ? '0 : idx + IW'(1);
      frame <= wrap;

      // Shown only changes at frame start so a frame never mixes two values.
      if (wrap && pend_valid) begin
        shown    <= pending;
        shown_dp <= pending_dp;
      end

      // A load on the wrap edge lands in pending and waits for the next frame.
      if (load) begin
        pending    <= valor;
        pending_dp <= dp_mask;
        pend_valid <= 1'b1;
      end else if (wrap) begin
        pend_valid <= 1'b0;
      end

      dado   <= cur_nib;
      dp     <= cur_dp;
      anodos <= anode_next;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// tb/tb_display_scan_mux.sv - scoreboard bench for display_scan_mux (DIV=4, GUARD=1, 4 digits, active-low anodes)

module tb_display_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] valor;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic        enable;
  logic [3:0]  dado;
  logic        dp;
  logic [3:0]  anodos;
  logic        frame;

  int errors = 0;
  int checks = 0;

  // Expected {dado, dp, anodos, frame} per cycle, sampled at negedge.
  logic [9:0] exp_q[$];

  display_scan_mux #(
    .NUM_DIGITS (4),
    .DIV        (4),
    .GUARD      (1),
    .ANODE_LOW  (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .valor    (valor),
    .dp_mask  (dp_mask),
    .blank_lz (blank_lz),
    .enable   (enable),
    .dado     (dado),
    .dp       (dp),
    .anodos   (anodos),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output seen at position pos (0..15) of a frame: each digit slot is one
  // dark guard cycle followed by three lit cycles; the frame pulse coincides
  // with the last cycle of digit 3.
  function automatic logic [9:0] frame_entry(input logic [15:0] v, input logic [3:0] m,
                                             input logic blk, input int pos);
    int         d;
    int         ph;
    logic [3:0] nib;
    logic       dark;
    logic [3:0] an;
    d    = pos / 4;
    ph   = pos % 4;
    nib  = v[4*d +: 4];
    dark = 1'b0;
    if (blk && d > 0) begin
      dark = 1'b1;
      for (int j = d; j < 4; j++)
        if (v[4*j +: 4] != 4'h0 || m[j]) dark = 1'b0;
    end
    an = 4'b1111;
    if (ph != 0 && !dark) an[d] = 1'b0;
    return {nib, m[d], an, (pos == 15)};
  endfunction

  function automatic void push_frame(input logic [15:0] v, input logic [3:0] m, input logic blk);
    for (int p = 0; p < 16; p++) exp_q.push_back(frame_entry(v, m, blk, p));
  endfunction

  task automatic test_reset();
    logic [9:0] got;
    logic [9:0] expv;
    rst = 1'b1; load = 1'b0; valor = '0; dp_mask = '0; blank_lz = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back({4'h0, 1'b0, 4'b1111, 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {dado, dp, anodos, frame}; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
        errors++; $display("FAIL reset cyc=%0d got=%b expected=%b", i, got, expv);
      end
    end
    rst = 1'b0;
    push_frame(16'h0000, 4'b0000, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      got = {dado, dp, anodos, frame}; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
        errors++; $display("FAIL reset_release cyc=%0d got=%b expected=%b", i, got, expv);
      end
    end
  endtask

  task automatic test_pattern();
    logic [9:0] got;
    logic [9:0] expv;
    load = 1'b1; valor = 16'h12AF; dp_mask = 4'b0100;
    push_frame(16'h0000, 4'b0000, 1'b0);
    push_frame(16'h12AF, 4'b0100, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      got = {dado, dp, anodos, frame}; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
        errors++; $display("FAIL pattern cyc=%0d got=%b expected=%b", i, got, expv);
      end
      if (i == 1) load = 1'b0;
    end
  endtask

  task automatic test_blank();
    logic [9:0] got;
    logic [9:0] expv;
    blank_lz = 1'b1;
    load = 1'b1; valor = 16'h0030; dp_mask = 4'b0000;
    push_frame(16'h12AF, 4'b0100, 1'b1);
    push_frame(16'h0030, 4'b0000, 1'b1);
    push_frame(16'h0000, 4'b0000, 1'b1);
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      got = {dado, dp, anodos, frame}; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
        errors++; $display("FAIL blank cyc=%0d got=%b expected=%b", i, got, expv);
      end
      if (i == 1)  load = 1'b0;
      if (i == 16) begin load = 1'b1; valor = 16'h0000; dp_mask = 4'b0000; end
      if (i == 17) load = 1'b0;
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_no_tear();
    logic [9:0] got;
    logic [9:0] expv;
    push_frame(16'h0000, 4'b0000, 1'b0);
    push_frame(16'h2222, 4'b0000, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      got = {dado, dp, anodos, frame}; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
        errors++; $display("FAIL no_tear cyc=%0d got=%b expected=%b", i, got, expv);
      end
      if (i == 9)  begin load = 1'b1; valor = 16'h1111; end
      if (i == 10) load = 1'b0;
      if (i == 11) begin load = 1'b1; valor = 16'h2222; end
      if (i == 12) load = 1'b0;
    end
  endtask

  task automatic test_load_on_wrap();
    logic [9:0] got;
    logic [9:0] expv;
    push_frame(16'h2222, 4'b0000, 1'b0);
    push_frame(16'h2222, 4'b0000, 1'b0);
    push_frame(16'h3456, 4'b0001, 1'b0);
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      got = {dado, dp, anodos, frame}; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
        errors++; $display("FAIL load_on_wrap cyc=%0d got=%b expected=%b", i, got, expv);
      end
      if (i == 15) begin load = 1'b1; valor = 16'h3456; dp_mask = 4'b0001; end
      if (i == 16) load = 1'b0;
    end
  endtask

  task automatic test_enable();
    logic [9:0] got;
    logic [9:0] expv;
    logic [9:0] held;
    for (int p = 0; p < 6; p++) exp_q.push_back(frame_entry(16'h3456, 4'b0001, 1'b0, p));
    held = frame_entry(16'h3456, 4'b0001, 1'b0, 6);
    held[4:1] = 4'b1111;
    held[0]   = 1'b0;
    for (int n = 0; n < 10; n++) exp_q.push_back(held);
    for (int p = 6; p < 16; p++) exp_q.push_back(frame_entry(16'h3456, 4'b0001, 1'b0, p));
    push_frame(16'h9ABC, 4'b1000, 1'b0);
    for (int i = 1; i <= 42; i++) begin
      @(negedge clk);
      got = {dado, dp, anodos, frame}; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
        errors++; $display("FAIL enable cyc=%0d got=%b expected=%b", i, got, expv);
      end
      if (i == 6)  enable = 1'b0;
      if (i == 8)  begin load = 1'b1; valor = 16'h9ABC; dp_mask = 4'b1000; end
      if (i == 9)  load = 1'b0;
      if (i == 16) enable = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] got;
    logic [9:0] expv;
    load = 1'b1; valor = 16'h7777; dp_mask = 4'b1111;
    for (int p = 0; p < 5; p++) exp_q.push_back(frame_entry(16'h9ABC, 4'b1000, 1'b0, p));
    for (int n = 0; n < 2; n++) exp_q.push_back({4'h0, 1'b0, 4'b1111, 1'b0});
    push_frame(16'h0000, 4'b0000, 1'b0);
    push_frame(16'h0000, 4'b0000, 1'b0);
    for (int i = 1; i <= 39; i++) begin
      @(negedge clk);
      got = {dado, dp, anodos, frame}; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
        errors++; $display("FAIL reset_mid cyc=%0d got=%b expected=%b", i, got, expv);
      end
      if (i == 1) load = 1'b0;
      if (i == 5) rst = 1'b1;
      if (i == 7) rst = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_blank();
    test_no_tear();
    test_load_on_wrap();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
